// File: rtl/unidad_control_riesgos.sv
// -----------------------------------------------------------------------------
// unidad_control_riesgos
//
// Hazard and sequencing controller for the 5-stage F/D/E/M/W pipeline.
//
// It generates the stall and flush controls for the pipeline registers:
//   - With forwarding enabled, it detects load-use hazards.
//   - With forwarding disabled, it detects every RAW hazard against E and M.
//   - It owns the forwarding-disable bit. A mode change first drains the
//     pipeline, so the new mode never takes effect while writes are in flight.
//
// Optional feature (macro UNIDAD_RIESGOS_PERF_CNT_EN):
//   Saturating performance counters for stall cycles and branch flushes.
//   When the macro is undefined, both counter outputs are tied to zero and
//   no counter flops are built.
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge), asynchronous active-low reset
//   Rs1D_i, Rs2D_i          source registers of the instruction in D
//   RdE_i, RdM_i            destination registers in E and M
//   RegWriteE_i/M_i         E / M write the register file
//   LoadE_i                 instruction in E is a load
//   PCSrcE_i                taken branch/jump resolved in E
//   modo_req_i              single-cycle mode-change request
//   modo_sin_fw_i           requested mode (1 = forwarding off)
//   StallF_o, StallD_o      hold PC / hold IF/ID
//   FlushD_o, FlushE_o      clear IF/ID / clear ID/EX
//   desactivar_fw_o         forwarding disable, to the forwarding unit
//   modo_ack_o              one-cycle pulse once the requested mode is active
//   ocupado_o               controller is draining the pipeline
//   cnt_stall_o             stall-cycle counter (optional feature)
//   cnt_flush_o             branch-flush counter (optional feature)
// -----------------------------------------------------------------------------
module unidad_control_riesgos #(
  parameter int REG_BITS     = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter bit FW_DIS_RESET = 1'b0,
  parameter int CNT_BITS     = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [REG_BITS-1:0] Rs1D_i,
  input  logic [REG_BITS-1:0] Rs2D_i,
  input  logic [REG_BITS-1:0] RdE_i,
  input  logic [REG_BITS-1:0] RdM_i,
  input  logic                RegWriteE_i,
  input  logic                RegWriteM_i,
  input  logic                LoadE_i,
  input  logic                PCSrcE_i,
  input  logic                modo_req_i,
  input  logic                modo_sin_fw_i,
  output logic                StallF_o,
  output logic                StallD_o,
  output logic                FlushD_o,
  output logic                FlushE_o,
  output logic                desactivar_fw_o,
  output logic                modo_ack_o,
  output logic                ocupado_o,
  output logic [CNT_BITS-1:0] cnt_stall_o,
  output logic [CNT_BITS-1:0] cnt_flush_o
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } estado_t;

  // The drain counter only has to reach DRAIN_CYCLES-1.
  localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  estado_t       estado;
  logic [DW-1:0] cnt_drain;
  logic          modo_pendiente;

  logic          hit_e;
  logic          hit_m;
  logic          burbuja;

  // A source register matches a destination only when it is not x0.
  // x0 is never really written.
  function automatic logic fuente_coincide(input logic [REG_BITS-1:0] rs,
                                           input logic [REG_BITS-1:0] rd);
    return (rs != '0) && (rs == rd);
  endfunction

  // The register file is write-first, so W never needs a stall.
  assign hit_e = RegWriteE_i &
                 (fuente_coincide(Rs1D_i, RdE_i) | fuente_coincide(Rs2D_i, RdE_i));
  assign hit_m = RegWriteM_i &
                 (fuente_coincide(Rs1D_i, RdM_i) | fuente_coincide(Rs2D_i, RdM_i));

  // Bubble request.
  //   - While draining, a bubble is inserted every cycle.
  //   - With forwarding off, any RAW hazard against E or M stalls.
  //   - With forwarding on, only a load-use hazard stalls.
  always_comb begin
    burbuja = 1'b0;
    if (estado == DRAIN) begin
      burbuja = 1'b1;
    end else if (desactivar_fw_o) begin
      burbuja = hit_e | hit_m;
    end else begin
      burbuja = LoadE_i & hit_e;
    end
  end

  // A taken branch overrides the stall: the redirected PC must load while
  // the wrong-path instructions in D and E are flushed.
  always_comb begin
    StallF_o = 1'b0;
    StallD_o = 1'b0;
    FlushD_o = 1'b0;
    FlushE_o = 1'b0;
    if (rst_n_i) begin
      StallF_o = burbuja & ~PCSrcE_i;
      StallD_o = burbuja & ~PCSrcE_i;
      FlushD_o = PCSrcE_i;
      FlushE_o = PCSrcE_i | burbuja;
    end
  end

  assign ocupado_o = (estado == DRAIN);

  // Mode-change sequencer.
  //   - Asserting reset during a drain discards the pending mode.
  //   - The new mode is applied on the same edge that leaves DRAIN, so it is
  //     visible in the first RUN cycle together with the ack pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      estado          <= RUN;
      desactivar_fw_o <= FW_DIS_RESET;
      modo_ack_o      <= 1'b0;
      modo_pendiente  <= FW_DIS_RESET;
      cnt_drain       <= '0;
    end else begin
      modo_ack_o <= 1'b0;
      case (estado)
        RUN: begin
          if (modo_req_i) begin
            if (modo_sin_fw_i == desactivar_fw_o) begin
              modo_ack_o <= 1'b1;
            end else begin
              modo_pendiente <= modo_sin_fw_i;
              cnt_drain      <= '0;
              estado         <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (cnt_drain == DRAIN_LAST) begin
            desactivar_fw_o <= modo_pendiente;
            modo_ack_o      <= 1'b1;
            cnt_drain       <= '0;
            estado          <= RUN;
          end else begin
            cnt_drain <= cnt_drain + DW'(1);
          end
        end
        default: begin
          estado    <= RUN;
          cnt_drain <= '0;
        end
      endcase
    end
  end

`ifdef UNIDAD_RIESGOS_PERF_CNT_EN
  logic [CNT_BITS-1:0] cnt_stall_q;
  logic [CNT_BITS-1:0] cnt_flush_q;

  // Increment the counter, holding it at all-ones once it saturates.
  function automatic logic [CNT_BITS-1:0] inc_sat(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_stall_q <= '0;
      cnt_flush_q <= '0;
    end else begin
      if (StallD_o) begin
        cnt_stall_q <= inc_sat(cnt_stall_q);
      end
      if (PCSrcE_i) begin
        cnt_flush_q <= inc_sat(cnt_flush_q);
      end
    end
  end

  assign cnt_stall_o = cnt_stall_q;
  assign cnt_flush_o = cnt_flush_q;
`else
  assign cnt_stall_o = '0;
  assign cnt_flush_o = '0;
`endif

endmodule
